// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Accepts symbolic RV32I instruction descriptors over a valid/ready stream,
// assembles each one into a 32-bit machine word and writes the words into
// instruction memory at consecutive word addresses starting at BASE_ADDR.
// Illegal opcodes, out-of-range or misaligned immediates, and memory overflow
// abort the session with an error code.
module instr_encoder_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    input  logic                  last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH+1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    // Descriptor op classes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;

    // RV32I major opcodes
    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_BRCH = 7'b1100011;

    // Error codes
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OP    = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_FULL  = 2'b11;

    // Memory depth expressed in word_count's width, and the base byte address
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH+1:0] BASE_L  = BASE_ADDR[ADDR_WIDTH+1:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                state_r;
    logic                  last_r;
    logic [31:0]           enc_word_s;
    logic [1:0]            enc_code_s;
    logic [ADDR_WIDTH:0]   count_inc_s;
    logic [ADDR_WIDTH+1:0] slot_addr_s;

    // A value fits a signed 12-bit field when bits [31:11] are a pure sign extension
    function automatic logic fits_simm12(input logic [31:0] v);
        return (v[31:11] == {21{v[11]}});
    endfunction

    // A branch offset fits the signed 13-bit field and must be halfword aligned
    function automatic logic fits_branch(input logic [31:0] v);
        return (v[31:12] == {20{v[12]}}) && (v[0] == 1'b0);
    endfunction

    // R-type assembly
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2);
        return {f7, s2, s1, f3, d, OPC_R};
    endfunction

    // I-type assembly
    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [31:0] v);
        return {v[11:0], s1, f3, d, opc};
    endfunction

    // S-type assembly
    function automatic logic [31:0] enc_s(input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] v);
        return {v[11:5], s2, s1, 3'b010, v[4:0], OPC_STOR};
    endfunction

    // B-type assembly
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [31:0] v);
        return {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], OPC_BRCH};
    endfunction

    assign count_inc_s = word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign slot_addr_s = BASE_L + {word_count[ADDR_WIDTH-1:0], 2'b00};

    // Encode the presented descriptor and classify it; illegal op overrides range errors
    always_comb begin
        enc_word_s = 32'd0;
        enc_code_s = ERR_NONE;
        case (op)
            OP_ADD: enc_word_s = enc_r(7'b0000000, 3'b000, rd, rs1, rs2);
            OP_SUB: enc_word_s = enc_r(7'b0100000, 3'b000, rd, rs1, rs2);
            OP_AND: enc_word_s = enc_r(7'b0000000, 3'b111, rd, rs1, rs2);
            OP_OR:  enc_word_s = enc_r(7'b0000000, 3'b110, rd, rs1, rs2);
            OP_ADDI: begin
                enc_word_s = enc_i(OPC_IMM, 3'b000, rd, rs1, imm);
                if (fits_simm12(imm)) enc_code_s = ERR_NONE;
                else                  enc_code_s = ERR_RANGE;
            end
            OP_LW: begin
                enc_word_s = enc_i(OPC_LOAD, 3'b010, rd, rs1, imm);
                if (fits_simm12(imm)) enc_code_s = ERR_NONE;
                else                  enc_code_s = ERR_RANGE;
            end
            OP_SW: begin
                enc_word_s = enc_s(rs1, rs2, imm);
                if (fits_simm12(imm)) enc_code_s = ERR_NONE;
                else                  enc_code_s = ERR_RANGE;
            end
            OP_BEQ: begin
                enc_word_s = enc_b(3'b000, rs1, rs2, imm);
                if (fits_branch(imm)) enc_code_s = ERR_NONE;
                else                  enc_code_s = ERR_RANGE;
            end
            OP_BNE: begin
                enc_word_s = enc_b(3'b001, rs1, rs2, imm);
                if (fits_branch(imm)) enc_code_s = ERR_NONE;
                else                  enc_code_s = ERR_RANGE;
            end
            default: begin
                enc_word_s = 32'd0;
                enc_code_s = ERR_OP;
            end
        endcase
    end

    // Session FSM; every output is a register updated on state transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            last_r     <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_r    <= S_ACCEPT;
                        in_ready   <= 1'b1;
                        word_count <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        err_code   <= ERR_NONE;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (enc_code_s != ERR_NONE) begin
                            state_r  <= S_ERROR;
                            err      <= 1'b1;
                            err_code <= enc_code_s;
                        end else begin
                            state_r   <= S_WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= enc_word_s;
                            mem_addr  <= slot_addr_s;
                            last_r    <= last;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we     <= 1'b0;
                    word_count <= count_inc_s;
                    if (last_r) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                    end else if (count_inc_s == DEPTH_L) begin
                        state_r  <= S_ERROR;
                        err      <= 1'b1;
                        err_code <= ERR_FULL;
                    end else begin
                        state_r  <= S_ACCEPT;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule
